// File: rtl/shifter8_unit.sv
// 8-bit registered shift unit: load a byte, then shift the stored value
// left logical, right logical or right arithmetic by 0-3 bits per clock.
module shifter8_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] op,
  input  logic [1:0] shamt,
  input  logic [7:0] d_in,
  output logic [7:0] d_out
);

  typedef enum logic [2:0] {
    OpNop  = 3'b000,
    OpLoad = 3'b001,
    OpLsl  = 3'b010,
    OpLsr  = 3'b011,
    OpAsr  = 3'b100
  } op_e;

  logic [7:0] r_q, r_d;
  logic [7:0] lsl_s1, lsl_s2;
  logic [7:0] rsh_s1, rsh_s2;
  logic       fill_bit;

  // Left barrel network: stage by 1, then stage by 2.
  always_comb begin
    lsl_s1 = shamt[0] ? {r_q[6:0], 1'b0} : r_q;
    lsl_s2 = shamt[1] ? {lsl_s1[5:0], 2'b00} : lsl_s1;
  end

  // Right barrel network shared by LSR and ASR; only the fill bit differs.
  always_comb begin
    fill_bit = (op_e'(op) == OpAsr) ? r_q[7] : 1'b0;
    rsh_s1   = shamt[0] ? {fill_bit, r_q[7:1]} : r_q;
    rsh_s2   = shamt[1] ? {{2{fill_bit}}, rsh_s1[7:2]} : rsh_s1;
  end

  always_comb begin
    r_d = r_q;
    case (op_e'(op))
      OpNop:   r_d = r_q;
      OpLoad:  r_d = d_in;
      OpLsl:   r_d = lsl_s2;
      OpLsr:   r_d = rsh_s2;
      OpAsr:   r_d = rsh_s2;
      default: r_d = r_q;
    endcase
  end

  // reset_n is active-high despite its name; it overrides any op.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_q <= 8'h00;
    end else begin
      r_q <= r_d;
    end
  end

  assign d_out = r_q;

endmodule

// File: tb/tb_shifter8_unit.sv
// Table-driven directed test of shifter8_unit plus hand-written reset/shift sequences.
module tb_shifter8_unit;

  logic       clk;
  logic       reset_n;
  logic [2:0] op;
  logic [1:0] shamt;
  logic [7:0] d_in;
  logic [7:0] d_out;

  int checks;
  int errors;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] LOAD = 3'b001;
  localparam logic [2:0] LSL  = 3'b010;
  localparam logic [2:0] LSR  = 3'b011;
  localparam logic [2:0] ASR  = 3'b100;

  typedef struct {
    logic       rst;
    logic [2:0] op;
    logic [1:0] shamt;
    logic [7:0] d_in;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  shifter8_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .op      (op),
    .shamt   (shamt),
    .d_in    (d_in),
    .d_out   (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive at negedge, sample 1 time unit after the following posedge.
  task automatic step(input logic rst, input logic [2:0] o, input logic [1:0] s,
                      input logic [7:0] d, input logic [7:0] exp, input string name);
    @(negedge clk);
    reset_n = rst;
    op      = o;
    shamt   = s;
    d_in    = d;
    @(posedge clk);
    #1;
    checks++;
    if (d_out !== exp) begin
      errors++;
      $display("FAIL %s: d_out=%02h expected=%02h", name, d_out, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic [2:0] o, logic [1:0] s, logic [7:0] d,
                              logic [7:0] exp);
    vec_t v;
    v.rst = rst; v.op = o; v.shamt = s; v.d_in = d; v.exp = exp;
    return v;
  endfunction

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b1;
    op      = NOP;
    shamt   = 2'd0;
    d_in    = 8'h00;

    // Reset beats LOAD, then load
    vecs.push_back(mk(1, LOAD, 0, 8'h77, 8'h00));
    vecs.push_back(mk(0, LOAD, 0, 8'h77, 8'h77));
    // LSL
    vecs.push_back(mk(0, LSL, 0, 8'h00, 8'h77));
    vecs.push_back(mk(0, LSL, 1, 8'h00, 8'hEE));
    vecs.push_back(mk(0, LSL, 1, 8'h00, 8'hDC));
    vecs.push_back(mk(0, LSL, 1, 8'h00, 8'hB8));
    // LSR
    vecs.push_back(mk(0, LSR, 1, 8'h00, 8'h5C));
    vecs.push_back(mk(0, LOAD, 2, 8'h87, 8'h87));
    vecs.push_back(mk(0, LSR, 3, 8'h00, 8'h10));
    // ASR with sticky sign
    vecs.push_back(mk(0, LOAD, 0, 8'h87, 8'h87));
    vecs.push_back(mk(0, ASR, 1, 8'h00, 8'hC3));
    vecs.push_back(mk(0, ASR, 1, 8'h00, 8'hE1));
    vecs.push_back(mk(0, ASR, 1, 8'h00, 8'hF0));
    vecs.push_back(mk(0, ASR, 3, 8'h00, 8'hFE));
    vecs.push_back(mk(0, ASR, 3, 8'h00, 8'hFF));
    vecs.push_back(mk(0, LOAD, 0, 8'h70, 8'h70));
    vecs.push_back(mk(0, ASR, 3, 8'h00, 8'h0E));
    // Shift by 2 exercises the second stage alone
    vecs.push_back(mk(0, LOAD, 0, 8'hC0, 8'hC0));
    vecs.push_back(mk(0, LSR, 2, 8'h00, 8'h30));
    vecs.push_back(mk(0, LOAD, 0, 8'hC0, 8'hC0));
    vecs.push_back(mk(0, ASR, 2, 8'h00, 8'hF0));
    vecs.push_back(mk(0, LSL, 2, 8'h00, 8'hC0));
    // NOP, reserved ops, zero shift amounts hold the value
    vecs.push_back(mk(0, LOAD, 0, 8'h5A, 8'h5A));
    vecs.push_back(mk(0, NOP, 3, 8'hFF, 8'h5A));
    vecs.push_back(mk(0, 3'b101, 1, 8'hFF, 8'h5A));
    vecs.push_back(mk(0, 3'b110, 2, 8'hFF, 8'h5A));
    vecs.push_back(mk(0, 3'b111, 3, 8'hFF, 8'h5A));
    vecs.push_back(mk(0, LSR, 0, 8'hFF, 8'h5A));
    vecs.push_back(mk(0, ASR, 0, 8'hFF, 8'h5A));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].shamt, vecs[i].d_in, vecs[i].exp,
           $sformatf("vec%0d", i));
    end

    // Reset in the middle of a shift sequence overrides LOAD
    step(0, LOAD, 0, 8'hFF, 8'hFF, "seq_load_ff");
    step(0, LSL,  1, 8'h00, 8'hFE, "seq_lsl_fe");
    step(1, LOAD, 0, 8'h33, 8'h00, "seq_reset_over_load");
    step(0, NOP,  0, 8'h33, 8'h00, "seq_nop_after_reset_1");
    step(0, NOP,  2, 8'h33, 8'h00, "seq_nop_after_reset_2");

    // Cumulative LSL by 3 walks a bit off the top
    step(0, LOAD, 0, 8'h01, 8'h01, "walk_load");
    step(0, LSL,  3, 8'h00, 8'h08, "walk_lsl_1");
    step(0, LSL,  3, 8'h00, 8'h40, "walk_lsl_2");
    step(0, LSL,  3, 8'h00, 8'h00, "walk_lsl_3");

    // Positive value under ASR fills with zeros
    step(0, LOAD, 0, 8'h7F, 8'h7F, "asr_pos_load");
    step(0, ASR,  3, 8'h00, 8'h0F, "asr_pos_1");
    step(0, ASR,  3, 8'h00, 8'h01, "asr_pos_2");
    step(0, ASR,  1, 8'h00, 8'h00, "asr_pos_3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
